// File: rtl/mips_trace_buffer.sv
// Instruction trace buffer: captures retired {pc, instr, wb} entries
// in a ring and drains them oldest-first over a valid/ready port.
module mips_trace_buffer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cap_valid,
    input  logic [ADDR_W-1:0]            cap_pc,
    input  logic [31:0]                  cap_instr,
    input  logic [DATA_W-1:0]            cap_wb,
    input  logic                         arm,
    input  logic                         mode,
    input  logic                         trig_en,
    input  logic [ADDR_W-1:0]            trig_pc,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [ADDR_W+32+DATA_W-1:0]  rd_data,
    output logic                         rd_last,
    output logic                         busy,
    output logic                         done,
    output logic                         triggered,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + 32 + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     post_cnt_q, post_cnt_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     rd_left_q, rd_left_d;
    logic              trig_q, trig_d;
    logic              mode_q, mode_d;
    logic              trig_en_q, trig_en_d;
    logic [ADDR_W-1:0] trig_pc_q, trig_pc_d;

    logic [EW-1:0]     mem_q [DEPTH];

    logic              wr_en;
    logic              go_drain;
    logic [CW-1:0]     cnt_inc;
    logic [PW-1:0]     wr_inc;

    assign cnt_inc = (count_q == FULL) ? count_q : count_q + 1'b1;
    assign wr_inc  = wr_ptr_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        post_cnt_d = post_cnt_q;
        count_d    = count_q;
        rd_left_d  = rd_left_q;
        trig_d     = trig_q;
        mode_d     = mode_q;
        trig_en_d  = trig_en_q;
        trig_pc_d  = trig_pc_q;
        wr_en      = 1'b0;
        go_drain   = 1'b0;

        if (arm) begin
            // Restart wins over everything, including a same-cycle capture.
            state_d    = ARMED;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            post_cnt_d = '0;
            count_d    = '0;
            rd_left_d  = '0;
            trig_d     = 1'b0;
            mode_d     = mode;
            trig_en_d  = trig_en;
            trig_pc_d  = trig_pc;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED, POST: begin
                    if (cap_valid) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_inc;
                        count_d  = cnt_inc;
                        if (state_q == POST) begin
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == PW'(1)) go_drain = 1'b1;
                        end else if (mode_q) begin
                            if (cnt_inc == FULL) go_drain = 1'b1;
                        end else if (trig_en_q && cap_pc == trig_pc_q) begin
                            trig_d = 1'b1;
                            if (POST_TRIG == 0) begin
                                go_drain = 1'b1;
                            end else begin
                                post_cnt_d = PW'(POST_TRIG);
                                state_d    = POST;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        rd_left_d = rd_left_q - 1'b1;
                        if (rd_left_q == CW'(1)) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (go_drain) begin
            // A full ring starts at the oldest slot, which is the next write slot.
            state_d   = DRAIN;
            rd_left_d = cnt_inc;
            rd_ptr_d  = (cnt_inc == FULL) ? wr_inc : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            rd_left_q  <= '0;
            trig_q     <= 1'b0;
            mode_q     <= 1'b0;
            trig_en_q  <= 1'b0;
            trig_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_cnt_q <= post_cnt_d;
            count_q    <= count_d;
            rd_left_q  <= rd_left_d;
            trig_q     <= trig_d;
            mode_q     <= mode_d;
            trig_en_q  <= trig_en_d;
            trig_pc_q  <= trig_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {cap_pc, cap_instr, cap_wb};
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign rd_valid  = (state_q == DRAIN);
    assign rd_last   = rd_valid && (rd_left_q == CW'(1));
    assign busy      = (state_q == ARMED) || (state_q == POST);
    assign done      = (state_q == DRAIN);
    assign triggered = trig_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer with DEPTH=8, POST_TRIG=2.
module tb_mips_trace_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_pc = '0;
    logic [31:0] cap_instr = '0;
    logic [31:0] cap_wb = '0;
    logic        arm = 1'b0;
    logic        mode = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [95:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        done;
    logic        triggered;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;

    mips_trace_buffer #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(8), .POST_TRIG(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_instr(cap_instr), .cap_wb(cap_wb),
        .arm(arm), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .busy(busy), .done(done),
        .triggered(triggered), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] ent(input logic [31:0] pc);
        return {pc, 32'hA000_0000 | pc, ~pc};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] pc);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_instr = 32'hA000_0000 | pc;
        cap_wb    = ~pc;
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic start(input logic m, input logic en, input logic [31:0] tp);
        arm     = 1'b1;
        mode    = m;
        trig_en = en;
        trig_pc = tp;
        tick();
        arm = 1'b0;
    endtask

    task automatic drain(input string tag, input logic [31:0] pc0, input int n);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 96'(rd_valid), 96'(1));
            chk({tag, "_data"}, rd_data, ent(pc0 + 32'(4 * i)));
            chk({tag, "_last"}, 96'(rd_last), 96'(i == n - 1));
            tick();
        end
        rd_ready = 1'b0;
        chk({tag, "_end_valid"}, 96'(rd_valid), 96'(0));
        chk({tag, "_end_done"}, 96'(done), 96'(0));
    endtask

    initial begin
        #2;
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_trig", 96'(triggered), 96'(0));
        chk("rst_count", 96'(count), 96'(0));
        chk("rst_rdvalid", 96'(rd_valid), 96'(0));
        chk("rst_rdlast", 96'(rd_last), 96'(0));
        tick();
        reset_n = 1'b1;
        tick();

        cap(32'h100);
        chk("idle_ignore_count", 96'(count), 96'(0));
        chk("idle_ignore_busy", 96'(busy), 96'(0));

        // Fill-once capture
        start(1'b1, 1'b0, 32'h0);
        chk("m1_busy", 96'(busy), 96'(1));
        chk("m1_count0", 96'(count), 96'(0));
        for (int i = 0; i < 7; i++) cap(32'(4 * i));
        chk("m1_count7", 96'(count), 96'(7));
        chk("m1_notdone", 96'(done), 96'(0));
        cap(32'h1C);
        chk("m1_done", 96'(done), 96'(1));
        chk("m1_count8", 96'(count), 96'(8));
        chk("m1_busy_off", 96'(busy), 96'(0));
        cap(32'h20);
        cap(32'h24);
        chk("m1_count_hold", 96'(count), 96'(8));
        drain("m1", 32'h00, 8);

        // Wrap until PC trigger, then POST_TRIG more
        start(1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 16; i++) cap(32'(4 * i));
        chk("m0_trig_pre", 96'(triggered), 96'(0));
        chk("m0_count_sat", 96'(count), 96'(8));
        chk("m0_busy_pre", 96'(busy), 96'(1));
        cap(32'h40);
        chk("m0_trig", 96'(triggered), 96'(1));
        chk("m0_post_busy", 96'(busy), 96'(1));
        cap(32'h44);
        chk("m0_post2_done", 96'(done), 96'(0));
        cap(32'h48);
        chk("m0_done", 96'(done), 96'(1));
        chk("m0_count", 96'(count), 96'(8));
        cap(32'h4C);
        cap(32'h50);
        // Backpressure: output must hold
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 96'(rd_valid), 96'(1));
            chk("bp_data", rd_data, ent(32'h2C));
            chk("bp_last", 96'(rd_last), 96'(0));
            tick();
        end
        drain("m0", 32'h2C, 8);

        // Early trigger, partial buffer
        start(1'b0, 1'b1, 32'h04);
        for (int i = 0; i < 3; i++) cap(32'(4 * i));
        chk("early_notdone", 96'(done), 96'(0));
        cap(32'h0C);
        chk("early_done", 96'(done), 96'(1));
        chk("early_count", 96'(count), 96'(4));
        chk("early_trig", 96'(triggered), 96'(1));
        drain("early", 32'h00, 4);

        // Arm coincident with a capture discards that capture
        start(1'b1, 1'b0, 32'h0);
        cap(32'h200);
        cap(32'h204);
        chk("rearm_pre_count", 96'(count), 96'(2));
        cap_valid = 1'b1;
        cap_pc    = 32'h208;
        cap_instr = 32'hA000_0208;
        cap_wb    = ~32'h208;
        start(1'b1, 1'b0, 32'h0);
        cap_valid = 1'b0;
        chk("rearm_count0", 96'(count), 96'(0));
        for (int i = 0; i < 8; i++) cap(32'h300 + 32'(4 * i));
        chk("rearm_done", 96'(done), 96'(1));
        drain("rearm", 32'h300, 8);

        // No trigger enabled: stays armed indefinitely
        start(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) cap(32'(4 * i));
        chk("notrig_busy", 96'(busy), 96'(1));
        chk("notrig_done", 96'(done), 96'(0));
        chk("notrig_count", 96'(count), 96'(8));

        // Asynchronous reset mid-POST
        start(1'b0, 1'b1, 32'h04);
        cap(32'h00);
        cap(32'h04);
        chk("post_trig", 96'(triggered), 96'(1));
        cap(32'h08);
        chk("post_busy", 96'(busy), 96'(1));
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 96'(busy), 96'(0));
        chk("arst_done", 96'(done), 96'(0));
        chk("arst_trig", 96'(triggered), 96'(0));
        chk("arst_count", 96'(count), 96'(0));
        chk("arst_rdvalid", 96'(rd_valid), 96'(0));
        chk("arst_rdlast", 96'(rd_last), 96'(0));
        reset_n = 1'b1;
        tick();
        cap(32'h10);
        cap(32'h14);
        chk("after_rst_count", 96'(count), 96'(0));
        chk("after_rst_busy", 96'(busy), 96'(0));
        chk("after_rst_done", 96'(done), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_trace_buffer.md
MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 Parameter ADDR_W, default 32: PC width.
REQ-002 Parameter DATA_W, default 32: write-back data width.
REQ-003 Parameter DEPTH, default 16: trace entries; power of two, >=4.
REQ-004 Parameter POST_TRIG, default 8: entries captured after the trigger entry; 0..DEPTH-1.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 cap_valid  in  1  one instruction retired this cycle.
REQ-008 cap_pc  in  ADDR_W  PC of the retired instruction.
REQ-009 cap_instr  in  32  retired instruction word.
REQ-010 cap_wb  in  DATA_W  register write-back value; 0 when none.
REQ-011 arm  in  1  single-cycle pulse that starts a new capture.
REQ-012 mode  in  1  0 = wrap-until-trigger, 1 = fill-once; sampled on arm.
REQ-013 trig_en / trig_pc  in  1 / ADDR_W  PC-match trigger enable and address; sampled on arm.
REQ-014 rd_valid  out  1  rd_data holds a trace entry.
REQ-015 rd_ready  in  1  consumer accepts the entry.
REQ-016 rd_data  out  ADDR_W+32+DATA_W  entry {pc, instr, wb}.
REQ-017 rd_last  out  1  current entry is the newest.
REQ-018 busy / done / triggered  out  1 each  capture active / capture finished / trigger fired.
REQ-019 count  out  clog2(DEPTH)+1  valid entries held.

Function
REQ-020 States: IDLE, ARMED, POST, DRAIN; done=1 exactly in DRAIN; busy=1 in ARMED and POST.
REQ-021 arm in any state: next cycle state=ARMED, wr_ptr=0, count=0, triggered=0, rd_valid=0; a cap_valid in the same cycle is discarded.
REQ-022 ARMED/POST: each cap_valid writes the entry at wr_ptr, wr_ptr increments mod DEPTH, count saturates at DEPTH.
REQ-023 Mode 1: the write that makes count=DEPTH moves to DRAIN; the trigger is ignored.
REQ-024 Mode 0: wraps, overwriting the oldest entry; cap_valid with trig_en=1 and cap_pc==trig_pc writes that entry, sets triggered, loads post_cnt=POST_TRIG, and goes to POST; POST_TRIG=0 goes directly to DRAIN.
REQ-025 POST: each cap_valid writes and decrements post_cnt; the write that makes it 0 moves to DRAIN; further trigger matches are ignored.
REQ-026 cap_valid in IDLE or DRAIN is ignored.
REQ-027 DRAIN entry: rd_ptr = wr_ptr if count==DEPTH, else 0; entries are read oldest first.
REQ-028 rd_valid=1 while undrained entries remain; rd_data and rd_last stay stable while rd_valid=1 and rd_ready=0.
REQ-029 rd_valid&rd_ready advances rd_ptr mod DEPTH; the transfer with rd_last=1 returns to IDLE with rd_valid=0 next cycle.
REQ-030 rd_data is combinational from storage at rd_ptr; no added latency.
REQ-031 DRAIN with count=0 (trigger disabled, no captures): not reachable; mode 0 with trig_en=0 remains ARMED until re-armed.

Reset
REQ-032 reset_n=0 asynchronously forces: state=IDLE, wr_ptr=rd_ptr=post_cnt=0, count=0, rd_valid=0, rd_last=0, busy=done=triggered=0.
REQ-033 Storage contents are not reset; rd_data is don't-care while rd_valid=0.
REQ-034 Reset takes effect in any state, including mid-POST and mid-DRAIN; the partial trace is discarded.

Verification (DEPTH=8, POST_TRIG=2)
REQ-035 Mode 1, arm, 10 captures with pc 0x00..0x24 step 4 -> DRAIN after the 8th, count=8, read-out pc 0x00..0x1C, rd_last on 0x1C, 9th and 10th not stored.
REQ-036 Mode 0, trig_pc=0x40, pc 0x00..0x60 step 4 -> triggered=1 at 0x40, DRAIN after 0x48, read-out 0x2C..0x48 (8 entries).
REQ-037 Mode 0, trig_pc=0x04, pc 0x00 upward -> DRAIN after 0x0C, count=4, read-out 0x00,0x04,0x08,0x0C.
REQ-038 In DRAIN, hold rd_ready=0 for 3 cycles -> rd_valid=1 and rd_data unchanged, then one transfer per cycle with rd_ready=1.
REQ-039 reset_n=0 during POST -> all outputs 0 in the same cycle; after release, cap_valid is ignored until arm.
REQ-040 arm coincident with cap_valid in ARMED -> next cycle count=0, and that entry is absent from read-out.
